// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory bus between the load/store sequencer and memory.
//   master (lsu side): drives mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata;
//                      receives mem_ready, mem_rvalid, mem_rdata, mem_err.
//   slave  (memory side): the mirror image.
// Request channel is valid/ready; the response channel is a single-cycle
// mem_rvalid carrying read data or a write ack, with mem_err qualified by it.
interface lsu_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_valid;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              mem_err;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata, mem_err
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata, mem_err
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer between execute and the data-memory bus.
// Accepts one load or store at a time, issues it on the bus, and returns an
// extended load result or a fault with a one-cycle op_done pulse.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   op_load, op_store    request from the core, held until op_done
//   op_func3             RV32I funct3 (access width / signedness)
//   op_addr, op_wdata    effective byte address, store source
//   stall                combinational core stall
//   op_done, op_fault    completion pulse, fault flag valid with op_done
//   op_rdata             extended load data, valid with op_done
//   mem                  data-memory bus (lsu_ctrl_if.master)
//
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// accesses fault without touching the bus; otherwise the low address bits are
// forced to natural alignment and the access proceeds.
module lsu_ctrl #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_load,
   input  logic              op_store,
   input  logic [2:0]        op_func3,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [31:0]       op_wdata,
   output logic              stall,
   output logic              op_done,
   output logic              op_fault,
   output logic [31:0]       op_rdata,
   lsu_ctrl_if.master        mem
);

   typedef enum logic [2:0] {StIdle, StReq, StResp, StDone, StFault} state_e;

   state_e            state_q, state_d;
   logic              valid_q, we_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       wdata_q, rdata_q;
   logic [2:0]        func3_q;
   logic [1:0]        lane_q;

   logic              req, legal;
   logic [1:0]        lane;
   logic [3:0]        wstrb;
   logic [31:0]       wdata;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       rd_ext;

   // Request decode: legality, lane selection, strobes and replicated data.
   always_comb begin
      req   = op_load | op_store;
      legal = 1'b1;
      lane  = op_addr[1:0];
      wstrb = 4'b0000;
      wdata = op_wdata;

      if (op_load && op_store) legal = 1'b0;
      if (op_load) begin
         case (op_func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
            default: legal = 1'b0;
         endcase
      end
      if (op_store) begin
         case (op_func3)
            3'b000, 3'b001, 3'b010: ;
            default: legal = 1'b0;
         endcase
      end

      case (op_func3[1:0])
         2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (op_addr[0]) legal = 1'b0;
`else
            lane[0] = 1'b0;
`endif
         end
         2'b10: begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (op_addr[1:0] != 2'b00) legal = 1'b0;
`else
            lane = 2'b00;
`endif
         end
         default: ;
      endcase

      case (op_func3[1:0])
         2'b00: begin
            wstrb = 4'b0001 << lane;
            wdata = {4{op_wdata[7:0]}};
         end
         2'b01: begin
            wstrb = 4'b0011 << {lane[1], 1'b0};
            wdata = {2{op_wdata[15:0]}};
         end
         default: wstrb = 4'b1111;
      endcase
      if (!op_store) wstrb = 4'b0000;
   end

   // Load lane extraction and extension from the captured func3/lane.
   always_comb begin
      rd_byte = 8'(mem.mem_rdata >> {lane_q, 3'b000});
      rd_half = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (func3_q)
         3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  rd_ext = {24'h0, rd_byte};
         3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
         3'b101:  rd_ext = {16'h0, rd_half};
         default: rd_ext = mem.mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (req) state_d = legal ? StReq : StFault;
         StReq:   if (mem.mem_ready) state_d = StResp;
         // Response is only looked at here, so one accepted in the same cycle
         // as mem_ready cannot skip RESP.
         StResp:  if (mem.mem_rvalid) state_d = StDone;
         StDone:  state_d = StIdle;
         StFault: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wstrb_q <= 4'b0000;
         wdata_q <= 32'h0;
         func3_q <= 3'b000;
         lane_q  <= 2'b00;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && req && legal) begin
            valid_q <= 1'b1;
            we_q    <= op_store;
            addr_q  <= {op_addr[ADDR_W-1:2], 2'b00};
            wstrb_q <= wstrb;
            wdata_q <= wdata;
            func3_q <= op_func3;
            lane_q  <= lane;
         end else if (state_q == StReq && mem.mem_ready) begin
            valid_q <= 1'b0;
         end
         if (state_q == StResp && mem.mem_rvalid) begin
            err_q   <= mem.mem_err;
            rdata_q <= (mem.mem_err || we_q) ? 32'h0 : rd_ext;
         end
      end
   end

   always_comb begin
      op_done  = (state_q == StDone) || (state_q == StFault);
      op_fault = (state_q == StFault) || ((state_q == StDone) && err_q);
      op_rdata = rdata_q;
      stall    = req & ~op_done;
   end

   assign mem.mem_valid = valid_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wstrb = wstrb_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl. A hand-driven memory responder
// accepts after a chosen number of wait cycles and answers one cycle later.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_load, op_store;
   logic [2:0]  op_func3;
   logic [31:0] op_addr, op_wdata;
   logic        stall, op_done, op_fault;
   logic [31:0] op_rdata;

   int n_cmp = 0;
   int n_err = 0;

   lsu_ctrl_if #(.ADDR_W(32)) mem ();

   lsu_ctrl #(.ADDR_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_load  (op_load),
      .op_store (op_store),
      .op_func3 (op_func3),
      .op_addr  (op_addr),
      .op_wdata (op_wdata),
      .stall    (stall),
      .op_done  (op_done),
      .op_fault (op_fault),
      .op_rdata (op_rdata),
      .mem      (mem.master)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one request starting in the current cycle (cycle 0). Returns the
   // cycle op_done was seen (-1 on timeout) and what the bus carried.
   task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic er, input int rwait,
                        output int done_cyc, output logic [31:0] o_rdata,
                        output logic o_fault, output logic [31:0] s_addr,
                        output logic [3:0] s_strb, output logic [31:0] s_wdata,
                        output logic saw_valid, output logic stable,
                        output logic stall0);
      int   vcnt;
      logic acc;
      op_load = ld; op_store = st; op_func3 = f3; op_addr = a; op_wdata = wd;
      #1;
      stall0    = stall;
      done_cyc  = -1;
      o_rdata   = 32'h0;
      o_fault   = 1'b0;
      s_addr    = 32'h0;
      s_strb    = 4'h0;
      s_wdata   = 32'h0;
      saw_valid = 1'b0;
      stable    = 1'b1;
      vcnt      = 0;
      acc       = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         mem.mem_ready  = 1'b0;
         mem.mem_rvalid = 1'b0;
         mem.mem_err    = 1'b0;
         if (op_done) begin
            done_cyc = c;
            o_rdata  = op_rdata;
            o_fault  = op_fault;
            break;
         end
         if (acc) begin
            mem.mem_rvalid = 1'b1;
            mem.mem_rdata  = rd;
            mem.mem_err    = er;
            acc            = 1'b0;
         end
         if (mem.mem_valid) begin
            if (!saw_valid) begin
               s_addr  = mem.mem_addr;
               s_strb  = mem.mem_wstrb;
               s_wdata = mem.mem_wdata;
            end else if (mem.mem_addr !== s_addr || mem.mem_wstrb !== s_strb ||
                         mem.mem_wdata !== s_wdata) begin
               stable = 1'b0;
            end
            saw_valid = 1'b1;
            if (vcnt >= rwait) begin
               mem.mem_ready = 1'b1;
               acc           = 1'b1;
            end
            vcnt++;
         end
      end
      op_load  = 1'b0;
      op_store = 1'b0;
      mem.mem_ready  = 1'b0;
      mem.mem_rvalid = 1'b0;
      mem.mem_err    = 1'b0;
      tick();
   endtask

   int          dc;
   logic [31:0] rdv, sa, swd;
   logic [3:0]  ss;
   logic        flt, sv, stb, st0;

   initial begin
      rst = 1'b1;
      op_load = 1'b0; op_store = 1'b0; op_func3 = 3'b000; op_addr = 32'h0; op_wdata = 32'h0;
      mem.mem_ready = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'h0; mem.mem_err = 1'b0;
      repeat (2) tick();
      check_eq("rst_valid", 32'(mem.mem_valid), 32'h0);
      check_eq("rst_we", 32'(mem.mem_we), 32'h0);
      check_eq("rst_wstrb", 32'(mem.mem_wstrb), 32'h0);
      check_eq("rst_addr", mem.mem_addr, 32'h0);
      check_eq("rst_wdata", mem.mem_wdata, 32'h0);
      check_eq("rst_done", 32'(op_done), 32'h0);
      check_eq("rst_fault", 32'(op_fault), 32'h0);
      check_eq("rst_rdata", op_rdata, 32'h0);
      rst = 1'b0;
      tick();

      // lw, zero wait
      do_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("lw_stall0", 32'(st0), 32'h1);
      check_eq("lw_addr", sa, 32'h100);
      check_eq("lw_strb", 32'(ss), 32'h0);
      check_eq("lw_cycle", 32'(dc), 32'd3);
      check_eq("lw_rdata", rdv, 32'hDEADBEEF);
      check_eq("lw_fault", 32'(flt), 32'h0);

      // lb / lbu, lane 3
      do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("lb_rdata", rdv, 32'hFFFFFF80);
      check_eq("lb_addr", sa, 32'h100);
      do_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("lbu_rdata", rdv, 32'h00000080);

      // lh / lhu, upper halfword
      do_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("lh_rdata", rdv, 32'hFFFF8001);
      do_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("lhu_rdata", rdv, 32'h00008001);

      // sh with two ready wait states
      do_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 2, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("sh_strb", 32'(ss), 32'hC);
      check_eq("sh_wdata", swd, 32'hABCDABCD);
      check_eq("sh_stable", 32'(stb), 32'h1);
      check_eq("sh_cycle", 32'(dc), 32'd5);
      check_eq("sh_fault", 32'(flt), 32'h0);

      // sb lane 1
      do_op(0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("sb_strb", 32'(ss), 32'h2);
      check_eq("sb_wdata", swd, 32'hA5A5A5A5);

      // misaligned lw
      do_op(1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
`ifdef LSU_MISALIGN_TRAP_EN
      check_eq("mis_cycle", 32'(dc), 32'd1);
      check_eq("mis_fault", 32'(flt), 32'h1);
      check_eq("mis_novalid", 32'(sv), 32'h0);
`else
      check_eq("mis_addr", sa, 32'h100);
      check_eq("mis_cycle", 32'(dc), 32'd3);
      check_eq("mis_rdata", rdv, 32'hCAFEF00D);
      check_eq("mis_fault", 32'(flt), 32'h0);
`endif

      // sw with bus error
      do_op(0, 1, 3'b010, 32'h200, 32'h11223344, 32'h55555555, 1, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("err_cycle", 32'(dc), 32'd3);
      check_eq("err_fault", 32'(flt), 32'h1);
      check_eq("err_strb", 32'(ss), 32'hF);
      check_eq("err_wdata", swd, 32'h11223344);
      check_eq("err_rdata", rdv, 32'h0);

      // illegal store func3, and load+store together
      do_op(0, 1, 3'b011, 32'h300, 32'h0, 32'h0, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("ill_cycle", 32'(dc), 32'd1);
      check_eq("ill_fault", 32'(flt), 32'h1);
      check_eq("ill_novalid", 32'(sv), 32'h0);
      do_op(1, 1, 3'b010, 32'h300, 32'h0, 32'h0, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("ldst_fault", 32'(flt), 32'h1);

      // reset while in RESP, then a late response
      op_load = 1'b1; op_func3 = 3'b010; op_addr = 32'h100;
      tick();
      mem.mem_ready = 1'b1;
      tick();
      mem.mem_ready = 1'b0;
      rst = 1'b1;
      op_load = 1'b0;
      tick();
      check_eq("rr_valid", 32'(mem.mem_valid), 32'h0);
      check_eq("rr_done", 32'(op_done), 32'h0);
      rst = 1'b0;
      mem.mem_rvalid = 1'b1;
      mem.mem_rdata  = 32'h12345678;
      tick();
      mem.mem_rvalid = 1'b0;
      check_eq("rr_late0", 32'(op_done), 32'h0);
      tick();
      check_eq("rr_late1", 32'(op_done), 32'h0);
      do_op(1, 0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 0, 0, dc, rdv, flt, sa, ss, swd, sv, stb, st0);
      check_eq("rr_after_cycle", 32'(dc), 32'd3);
      check_eq("rr_after_rdata", rdv, 32'h0BADF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
